// File: rtl/cmd_sequencer.sv
// Button front-end for the counter/display datapath: debounce, press arbitration,
// a small command FIFO and a one-command-per-tick issue sequencer.
`timescale 1ns/1ps
module cmd_sequencer #(
  parameter int unsigned p_debounce   = 16,
  parameter int unsigned p_fifo_depth = 4
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_set,
  input  logic       btn_left2,
  input  logic       btn_right1,
  input  logic       btn_dcrm,
  input  logic       btn_pause,
  input  logic       btn_nsyst,
  output logic       set,
  output logic       shift_left2,
  output logic       shift_right1,
  output logic       dcrm,
  output logic       input_pause,
  output logic       nsyst,
  output logic       busy,
  output logic [2:0] fifo_level,
  output logic       overflow
);

  localparam int unsigned NBTN  = 6;
  localparam int unsigned CNT_W = $clog2(p_debounce + 1);
  localparam int unsigned PTR_W = $clog2(p_fifo_depth);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Bit order: 0 set, 1 left2, 2 right1, 3 dcrm, 4 pause, 5 nsyst
  logic [NBTN-1:0]  w_btn_raw;
  logic [NBTN-1:0]  r_sync1, r_sync2, r_deb, r_deb_d;
  logic [CNT_W-1:0] r_cnt [NBTN];
  logic [NBTN-1:0]  w_press;

  logic             r_pause, r_nsyst, r_ovf;
  logic [3:0]       r_pend, w_grant, w_pend_next;
  logic [1:0]       w_wr_cmd;
  logic             w_wr, w_ovf;

  logic [1:0]       r_mem [p_fifo_depth];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0] r_count;
  logic             w_full, w_empty, w_pop;

  logic [1:0]       r_state, w_state_next;
  logic [1:0]       r_cmd, w_cmd_next;
  logic [3:0]       r_lines, w_lines_next;
  logic             r_busy;

  assign w_btn_raw = {btn_nsyst, btn_pause, btn_dcrm, btn_right1, btn_left2, btn_set};
  assign w_press   = r_deb & ~r_deb_d;

  // Synchronize, then flip the debounced level after p_debounce stable cycles
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < NBTN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNT_W'(p_debounce - 1)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_full  = (r_count == LVL_W'(p_fifo_depth));
  assign w_empty = (r_count == '0);

  // Fixed-priority pick of one pending command per cycle while the FIFO has room
  always_comb begin
    w_grant  = '0;
    w_wr_cmd = 2'd0;
    if (!w_full) begin
      if (r_pend[0]) begin
        w_grant[0] = 1'b1;
        w_wr_cmd   = 2'd0;
      end else if (r_pend[1]) begin
        w_grant[1] = 1'b1;
        w_wr_cmd   = 2'd1;
      end else if (r_pend[2]) begin
        w_grant[2] = 1'b1;
        w_wr_cmd   = 2'd2;
      end else if (r_pend[3]) begin
        w_grant[3] = 1'b1;
        w_wr_cmd   = 2'd3;
      end
    end
    w_wr        = |w_grant;
    w_pend_next = (r_pend & ~w_grant) | w_press[3:0];
    w_ovf       = |(w_press[3:0] & r_pend & ~w_grant);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_pause <= 1'b0;
      r_nsyst <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      if (w_ovf)      r_ovf   <= 1'b1;
      if (w_press[4]) r_pause <= ~r_pause;
      if (w_press[5]) r_nsyst <= ~r_nsyst;
    end
  end

  // Payload storage needs no reset; occupancy and pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= w_wr_cmd;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: a tick is only honoured once the line has been up for a full cycle
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty && !r_pause) begin
        w_pop        = 1'b1;
        w_state_next = S_ARM;
      end
      S_ARM:   if (tick) w_state_next = S_GAP;
      S_GAP:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_cmd_next   = w_pop ? r_mem[r_rptr] : r_cmd;
    w_lines_next = '0;
    if (w_state_next == S_ARM) w_lines_next[w_cmd_next] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cmd   <= 2'd0;
      r_lines <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cmd   <= w_cmd_next;
      r_lines <= w_lines_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  assign set          = r_lines[0];
  assign shift_left2  = r_lines[1];
  assign shift_right1 = r_lines[2];
  assign dcrm         = r_lines[3];
  assign input_pause  = r_pause;
  assign nsyst        = r_nsyst;
  assign busy         = r_busy;
  assign fifo_level   = 3'(r_count);
  assign overflow     = r_ovf;

endmodule
